// File: rtl/seq_barrel_shifter_if.sv
// -----------------------------------------------------------------------------
// seq_barrel_shifter_if
// Handshake bundle for the sequential barrel shifter.
//
//   in_valid  : producer has a word + controls to shift
//   in_ready  : shifter can take a new transaction
//   in_data   : N-bit word to shift
//   in_shamt  : shift amount, 0..N-1
//   in_mode   : 00 SLL, 01 SRL, 10 SRA, 11 ROR
//   out_valid : out_data holds a finished result
//   out_ready : consumer takes the result
//   out_data  : N-bit shifted result
//
// Modports: slave = the shifter, master = the producer/consumer side.
// -----------------------------------------------------------------------------
interface seq_barrel_shifter_if #(
   parameter  int N = 32,
   localparam int S = $clog2(N)
);
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] in_data;
   logic [S-1:0] in_shamt;
   logic [1:0]   in_mode;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] out_data;

   modport slave (
      input  in_valid, in_data, in_shamt, in_mode, out_ready,
      output in_ready, out_valid, out_data
   );

   modport master (
      output in_valid, in_data, in_shamt, in_mode, out_ready,
      input  in_ready, out_valid, out_data
   );
endinterface

// File: rtl/seq_barrel_shifter.sv
// -----------------------------------------------------------------------------
// seq_barrel_shifter
// Multi-cycle barrel shifter: one log2 mux stage is applied per clock, so a
// full shift takes S = log2(N) cycles. Accepts one word per transaction on the
// input handshake and holds the result on the output handshake until taken.
//
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset (aborts any transaction in flight)
//   bus : seq_barrel_shifter_if.slave (in_* request side, out_* result side)
//
// Timing: acceptance at edge E0 -> out_valid at edge E0+S. Minimum initiation
// interval S+2 with out_ready held high.
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// sbs_stage
// One fixed-distance shift stage (distance SH) for all four modes.
//   i_data : working word
//   i_mode : 00 SLL, 01 SRL, 10 SRA, 11 ROR
//   o_data : word shifted by SH according to i_mode
// -----------------------------------------------------------------------------
module sbs_stage #(
   parameter int N  = 32,
   parameter int SH = 1
) (
   input  logic [N-1:0] i_data,
   input  logic [1:0]   i_mode,
   output logic [N-1:0] o_data
);
   localparam logic [1:0] MODE_SLL = 2'b00;
   localparam logic [1:0] MODE_SRL = 2'b01;
   localparam logic [1:0] MODE_SRA = 2'b10;
   localparam logic [1:0] MODE_ROR = 2'b11;

   // SH never exceeds N/2, so every slice below is non-empty.
   always_comb begin
      o_data = i_data;
      case (i_mode)
         MODE_SLL: o_data = {i_data[N-SH-1:0], {SH{1'b0}}};
         MODE_SRL: o_data = {{SH{1'b0}}, i_data[N-1:SH]};
         MODE_SRA: o_data = {{SH{i_data[N-1]}}, i_data[N-1:SH]};
         MODE_ROR: o_data = {i_data[SH-1:0], i_data[N-1:SH]};
         default:  o_data = i_data;
      endcase
   end
endmodule

module seq_barrel_shifter #(
   parameter  int N = 32,
   localparam int S = $clog2(N)
) (
   input  logic                  clk,
   input  logic                  rst,
   seq_barrel_shifter_if.slave   bus
);
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam logic [S-1:0] K_LAST = S'(S - 1);

   logic [1:0]   r_state;
   logic [S-1:0] r_k;
   logic [N-1:0] r_work;
   logic [S-1:0] r_shamt;
   logic [1:0]   r_mode;

   logic             w_in_ready;
   logic             w_accept;
   logic [S-1:0][N-1:0] w_stage;
   logic [N-1:0]     w_stage_sel;

   // One shifter per stage distance 2^g; the counter picks which one lands.
   for (genvar g = 0; g < S; g++) begin : g_stage
      sbs_stage #(.N(N), .SH(2 ** g)) u_stage (
         .i_data (r_work),
         .i_mode (r_mode),
         .o_data (w_stage[g])
      );
   end

   assign w_stage_sel = w_stage[r_k];

   // rst is folded in so in_ready reads 0 for the whole reset window even
   // though the state register already sits in IDLE.
   assign w_in_ready = (r_state == ST_IDLE) && !rst;
   assign w_accept   = bus.in_valid && w_in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_k     <= '0;
         r_work  <= '0;
         r_shamt <= '0;
         r_mode  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_work  <= bus.in_data;
                  r_shamt <= bus.in_shamt;
                  r_mode  <= bus.in_mode;
                  r_k     <= '0;
                  r_state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               // Every stage is visited even when its shamt bit is 0, which
               // keeps latency fixed at S regardless of the shift amount.
               if (r_shamt[r_k]) r_work <= w_stage_sel;
               r_k <= r_k + 1'b1;
               if (r_k == K_LAST) r_state <= ST_DONE;
            end
            ST_DONE: begin
               if (bus.out_ready) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Outputs come straight from registers/state, so reset drops out_valid
   // and clears out_data at once.
   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = (r_state == ST_DONE);
   assign bus.out_data  = r_work;
endmodule

// File: tb/tb_seq_barrel_shifter.sv
module tb_seq_barrel_shifter;
   localparam int N = 8;
   localparam int S = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   seq_barrel_shifter_if #(.N(N)) bus ();

   seq_barrel_shifter #(.N(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;
   int rdy_pct = 100;

   // model state
   logic [N-1:0] sb[$];
   bit           m_pending = 0;
   int           m_e0 = 0;
   bit           prev_ov = 0;
   logic [N-1:0] last_out = '0;
   int           last_lat = 0;
   int           n_acc = 0;
   int           n_xfer = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference: whole shift in one go by the full amount.
   function automatic logic [N-1:0] ref_shift(input logic [N-1:0] d, input int sh, input logic [1:0] m);
      logic signed [N-1:0] sd;
      logic [2*N-1:0]      dd;
      sd = d;
      dd = {d, d} >> sh;
      case (m)
         2'b00:   return d << sh;
         2'b01:   return d >> sh;
         2'b10:   return sd >>> sh;
         default: return dd[N-1:0];
      endcase
   endfunction

   always @(posedge clk) cyc++;

   always @(posedge clk) begin
      #1;
      bus.out_ready = ($urandom_range(0, 99) < rdy_pct);
   end

   // Compare process: sampled at negedge, mid-cycle.
   always @(negedge clk) begin
      bit exp_ov;
      if (rst) begin
         chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
         chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
         chk("rst_out_data", {24'b0, bus.out_data}, 32'd0);
         sb.delete();
         m_pending = 0;
         prev_ov = 0;
      end else begin
         exp_ov = m_pending && (cyc >= m_e0 + S);
         chk("in_ready", {31'b0, bus.in_ready}, {31'b0, !m_pending});
         chk("out_valid", {31'b0, bus.out_valid}, {31'b0, exp_ov});
         if (bus.out_valid) begin
            if (!prev_ov) last_lat = cyc - m_e0;
            if (sb.size() == 0) chk("out_unexpected", {31'b0, bus.out_valid}, 32'd0);
            else                chk("out_data", {24'b0, bus.out_data}, {24'b0, sb[0]});
         end
         prev_ov = bus.out_valid;
         if (bus.out_valid && bus.out_ready && exp_ov && sb.size() != 0) begin
            last_out  = sb.pop_front();
            m_pending = 0;
            n_xfer++;
         end else if (bus.in_valid && bus.in_ready && !m_pending) begin
            sb.push_back(ref_shift(bus.in_data, int'(bus.in_shamt), bus.in_mode));
            m_pending = 1;
            m_e0 = cyc + 1;
            n_acc++;
         end
      end
   end

   // Present a transaction and hold it until accepted; returns posedge+1.
   task automatic send(input logic [N-1:0] d, input int sh, input logic [1:0] m);
      bit ok = 0;
      bit acc;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_shamt = sh[S-1:0];
      bus.in_mode  = m;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         acc = bus.in_ready;
         @(posedge clk);
         #1;
         if (acc) begin ok = 1; break; end
      end
      chk("accept_timeout", {31'b0, ok}, 32'd1);
      bus.in_valid = 1'b0;
      bus.in_data  = N'($urandom);
      bus.in_shamt = S'($urandom);
      bus.in_mode  = 2'($urandom);
   endtask

   task automatic wait_idle();
      bit done = 0;
      for (int i = 0; i < 500; i++) begin
         @(posedge clk);
         if (!m_pending && sb.size() == 0) begin done = 1; break; end
      end
      #1;
      chk("idle_timeout", {31'b0, done}, 32'd1);
   endtask

   task automatic directed(input string nm, input logic [N-1:0] d, input int sh,
                           input logic [1:0] m, input logic [N-1:0] exp);
      send(d, sh, m);
      wait_idle();
      chk(nm, {24'b0, last_out}, {24'b0, exp});
      chk({nm, "_lat"}, last_lat, S);
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.in_shamt = '0;
      bus.in_mode  = '0;

      // pin the model with hand-computed values
      chk("model_sra", {24'b0, ref_shift(8'h96, 3, 2'b10)}, 32'hF2);
      chk("model_ror", {24'b0, ref_shift(8'h96, 3, 2'b11)}, 32'hD2);
      chk("model_sll", {24'b0, ref_shift(8'h96, 5, 2'b00)}, 32'hC0);
      chk("model_srl", {24'b0, ref_shift(8'h96, 1, 2'b01)}, 32'h4B);

      repeat (3) @(posedge clk);
      #1;
      chk("reset_in_ready", {31'b0, bus.in_ready}, 32'd0);
      chk("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("reset_out_data", {24'b0, bus.out_data}, 32'd0);
      #2 rst = 1'b0;
      @(posedge clk); #1;
      chk("post_reset_in_ready", {31'b0, bus.in_ready}, 32'd1);

      directed("sra_96_3", 8'h96, 3, 2'b10, 8'hF2);
      directed("ror_96_3", 8'h96, 3, 2'b11, 8'hD2);
      directed("sll_96_5", 8'h96, 5, 2'b00, 8'hC0);
      directed("srl_96_1", 8'h96, 1, 2'b01, 8'h4B);
      for (int m = 0; m < 4; m++) directed("shamt0", 8'hA5, 0, 2'(m), 8'hA5);

      // backpressure: stall in DONE, wiggle inputs
      rdy_pct = 0;
      send(8'h5A, 4, 2'b11);
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 10; i++) begin
         bus.in_valid = 1'($urandom_range(0, 1));
         bus.in_data  = N'($urandom);
         bus.in_shamt = S'($urandom);
         bus.in_mode  = 2'($urandom);
         @(posedge clk); #1;
         chk("stall_valid", {31'b0, bus.out_valid}, 32'd1);
         chk("stall_data", {24'b0, bus.out_data}, 32'hA5);
      end
      bus.in_valid = 1'b0;
      rdy_pct = 100;
      wait_idle();
      chk("stall_result", {24'b0, last_out}, 32'hA5);

      // async reset mid-SHIFT
      send(8'hFF, 7, 2'b00);
      #2 rst = 1'b1;
      #1;
      chk("rst_shift_out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("rst_shift_out_data", {24'b0, bus.out_data}, 32'd0);
      chk("rst_shift_in_ready", {31'b0, bus.in_ready}, 32'd0);
      @(posedge clk); @(posedge clk);
      #3 rst = 1'b0;
      directed("after_rst", 8'h3C, 2, 2'b00, 8'hF0);

      // async reset while holding a result in DONE
      rdy_pct = 0;
      send(8'h81, 1, 2'b10);
      repeat (3) @(posedge clk);
      #1;
      chk("done_valid", {31'b0, bus.out_valid}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("rst_done_out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("rst_done_out_data", {24'b0, bus.out_data}, 32'd0);
      @(posedge clk);
      #3 rst = 1'b0;
      rdy_pct = 100;
      directed("after_rst2", 8'h81, 1, 2'b10, 8'hC0);

      // random soak
      n_acc  = 0;
      n_xfer = 0;
      rdy_pct = 60;
      for (int t = 0; t < 1024; t++) begin
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
         send(N'($urandom), $urandom_range(0, N - 1), 2'($urandom));
      end
      rdy_pct = 100;
      wait_idle();
      chk("soak_accepts", n_acc, 1024);
      chk("soak_transfers", n_xfer, 1024);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
